sd_word_scanner: RTL and testbench

SD_WORD_SCANNER -- requirements
Module: sd_word_scanner

---
 rtl/sd_scan_pkg.sv | 30 +++
 rtl/tag_window.sv | 48 ++++
 rtl/sd_word_scanner.sv | 188 ++++++++++++++++++
 tb/tb_sd_word_scanner.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_scan_pkg.sv
// Shared types and constants for the SD word scanner.
// Macro SD_SCAN_ALNUM_EN: when defined, digits 0-9 also count as word characters.
package sd_scan_pkg;

    localparam int unsigned TAG_BYTES = 8;
    localparam int unsigned BLK_BYTES = 512;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_FIND,
        ST_SCAN,
        ST_NBLK,
        ST_DONE,
        ST_FAIL
    } state_t;

    // Letters always qualify; digits only in the alphanumeric build.
    function automatic logic is_word_char(input logic [7:0] c);
        logic res;
        res = ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
`ifdef SD_SCAN_ALNUM_EN
        res = res || ((c >= 8'h30) && (c <= 8'h39));
`else
        res = res && 1'b1;
`endif
        return res;
    endfunction

endpackage

// File: rtl/tag_window.sv
// Eight-byte sliding window over the incoming byte stream: tag compares and the
// byte leaving a full window. Compares look at the window as it will be after this shift.
module tag_window
    import sd_scan_pkg::*;
#(
    parameter logic [63:0] START_TAG = "DLAB_TAG",
    parameter logic [63:0] END_TAG   = "DLAB_END"
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       shift,
    input  logic [7:0] din,
    output logic       start_hit_c,
    output logic       end_hit_c,
    output logic       out_valid_c,
    output logic [7:0] out_byte_c
);
    localparam int unsigned WIN_W  = TAG_BYTES * 8;
    localparam int unsigned FILL_W = 4;

    logic [WIN_W-1:0]  win;
    logic [WIN_W-1:0]  win_nxt;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nxt;
    logic              full_nxt;

    // Newest byte enters at the LSB, so the oldest byte sits in the top octet.
    assign win_nxt  = {win[WIN_W-9:0], din};
    assign fill_nxt = (fill == FILL_W'(TAG_BYTES)) ? fill : fill + 1'b1;
    assign full_nxt = (fill_nxt == FILL_W'(TAG_BYTES));

    assign start_hit_c = shift && full_nxt && (win_nxt == START_TAG);
    assign end_hit_c   = shift && full_nxt && (win_nxt == END_TAG);
    assign out_valid_c = shift && (fill == FILL_W'(TAG_BYTES));
    assign out_byte_c  = win[WIN_W-1 -: 8];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            win  <= '0;
            fill <= '0;
        end else if (shift) begin
            win  <= win_nxt;
            fill <= fill_nxt;
        end
    end

endmodule

// File: rtl/sd_word_scanner.sv
// Reads SD blocks from START_ADDR, locates START_TAG..END_TAG and counts words of
// exactly WORD_LEN characters in between. SD_SCAN_ALNUM_EN adds digits to word characters.
module sd_word_scanner
    import sd_scan_pkg::*;
#(
    parameter logic [31:0] START_ADDR = 32'h0000_2000,
    parameter int unsigned MAX_BLKS   = 1024,
    parameter int unsigned WORD_LEN   = 3,
    parameter int unsigned CNT_W      = 16,
    parameter logic [63:0] START_TAG  = "DLAB_TAG",
    parameter logic [63:0] END_TAG    = "DLAB_END"
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             rd_req,
    output logic [31:0]      block_addr,
    input  logic [7:0]       sd_dout,
    input  logic             sd_valid,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [CNT_W-1:0] word_count,
    output logic [31:0]      tag_blk
);
    localparam int unsigned BYTE_CNT_W = 10;
    localparam int unsigned BLK_CNT_W  = 16;
    localparam int unsigned RUN_W      = 4;

    state_t                state;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic [BLK_CNT_W-1:0]  blk_cnt;
    logic [RUN_W-1:0]      run;

    logic             launch;
    logic             in_stream;
    logic             shift;
    logic             blk_done;
    logic             last_blk;
    logic             win_clear;
    logic             start_hit;
    logic             end_hit;
    logic             out_valid;
    logic [7:0]       out_byte;
    logic [RUN_W-1:0] run_nxt;
    logic             cnt_inc;
    logic [CNT_W-1:0] word_count_nxt;

    assign launch    = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_FAIL));
    assign in_stream = (state == ST_FIND) || (state == ST_SCAN);
    assign shift     = sd_valid && in_stream;
    assign blk_done  = shift && (byte_cnt == BYTE_CNT_W'(BLK_BYTES - 1));
    assign last_blk  = (blk_cnt == BLK_CNT_W'(MAX_BLKS));
    assign win_clear = launch
                     || ((state == ST_FIND) && start_hit)
                     || ((state == ST_SCAN) && end_hit);

    tag_window #(
        .START_TAG (START_TAG),
        .END_TAG   (END_TAG)
    ) u_tag_window (
        .clk         (clk),
        .rst         (rst),
        .clear       (win_clear),
        .shift       (shift),
        .din         (sd_dout),
        .start_hit_c (start_hit),
        .end_hit_c   (end_hit),
        .out_valid_c (out_valid),
        .out_byte_c  (out_byte)
    );

    // Classify the byte leaving the window; an END_TAG hit also flushes the open run.
    always_comb begin
        run_nxt        = run;
        cnt_inc        = 1'b0;
        word_count_nxt = word_count;
        if ((state == ST_SCAN) && out_valid) begin
            if (is_word_char(out_byte)) begin
                if (run != RUN_W'(WORD_LEN + 1)) begin
                    run_nxt = run + 1'b1;
                end
            end else begin
                cnt_inc = (run == RUN_W'(WORD_LEN));
                run_nxt = '0;
            end
        end
        if ((state == ST_SCAN) && end_hit && (run_nxt == RUN_W'(WORD_LEN))) begin
            cnt_inc = 1'b1;
        end
        if (cnt_inc && (word_count != '1)) begin
            word_count_nxt = word_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rd_req     <= 1'b0;
            block_addr <= START_ADDR;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            word_count <= '0;
            tag_blk    <= '0;
            byte_cnt   <= '0;
            blk_cnt    <= '0;
            run        <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start) begin
                        state      <= ST_REQ;
                        rd_req     <= 1'b1;
                        block_addr <= START_ADDR;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        fail       <= 1'b0;
                        word_count <= '0;
                        byte_cnt   <= '0;
                        blk_cnt    <= BLK_CNT_W'(1);
                        run        <= '0;
                    end
                end
                ST_REQ: begin
                    rd_req <= 1'b0;
                    state  <= ST_FIND;
                end
                ST_NBLK: begin
                    rd_req <= 1'b0;
                    state  <= ST_SCAN;
                end
                ST_FIND: begin
                    if (shift) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        if (start_hit) begin
                            tag_blk <= block_addr;
                            run     <= '0;
                        end
                        // A tag ending on the last byte of a block still needs the next block.
                        if (blk_done && last_blk) begin
                            state <= ST_FAIL;
                            busy  <= 1'b0;
                            fail  <= 1'b1;
                        end else if (blk_done) begin
                            state      <= start_hit ? ST_NBLK : ST_REQ;
                            rd_req     <= 1'b1;
                            block_addr <= block_addr + 32'd1;
                            blk_cnt    <= blk_cnt + 1'b1;
                            byte_cnt   <= '0;
                        end else if (start_hit) begin
                            state <= ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    if (shift) begin
                        byte_cnt   <= byte_cnt + 1'b1;
                        word_count <= word_count_nxt;
                        run        <= run_nxt;
                        if (end_hit) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            run   <= '0;
                        end else if (blk_done && last_blk) begin
                            state <= ST_FAIL;
                            busy  <= 1'b0;
                            fail  <= 1'b1;
                        end else if (blk_done) begin
                            state      <= ST_NBLK;
                            rd_req     <= 1'b1;
                            block_addr <= block_addr + 32'd1;
                            blk_cnt    <= blk_cnt + 1'b1;
                            byte_cnt   <= '0;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    rd_req <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_word_scanner.sv
// Scoreboard bench for sd_word_scanner: a stream-level model predicts block requests
// and the final result; a monitor compares them as the DUT presents them.
module tb_sd_word_scanner;
    localparam logic [31:0] START_ADDR = 32'h0000_2000;
    localparam int MAXB = 6;
    localparam int WLEN = 3;
    localparam int CW   = 3;
    localparam int MEMB = 8;
    localparam int BLK  = 512;
    localparam logic [63:0] S_TAG = "DLAB_TAG";
    localparam logic [63:0] E_TAG = "DLAB_END";

    typedef struct {
        logic          done;
        logic          fail;
        logic [CW-1:0] wc;
        logic [31:0]   tag;
    } res_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          rd_req;
    logic [31:0]   block_addr;
    logic [7:0]    sd_dout;
    logic          sd_valid;
    logic          busy;
    logic          done;
    logic          fail;
    logic [CW-1:0] word_count;
    logic [31:0]   tag_blk;

    logic [7:0]  mem [MEMB*BLK];
    logic [31:0] addr_q [$];
    res_t        res_q [$];
    logic [31:0] model_tag;
    bit          pending;
    int          n_checks = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    sd_word_scanner #(
        .START_ADDR (START_ADDR),
        .MAX_BLKS   (MAXB),
        .WORD_LEN   (WLEN),
        .CNT_W      (CW),
        .START_TAG  (S_TAG),
        .END_TAG    (E_TAG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rd_req     (rd_req),
        .block_addr (block_addr),
        .sd_dout    (sd_dout),
        .sd_valid   (sd_valid),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .word_count (word_count),
        .tag_blk    (tag_blk)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit word_ch(input logic [7:0] c);
        bit r;
        r = (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
`ifdef SD_SCAN_ALNUM_EN
        r = r || (c >= 8'h30 && c <= 8'h39);
`endif
        return r;
    endfunction

    function automatic bit tag_at(input int i, input logic [63:0] tag);
        logic [63:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) w = {w[55:0], mem[i-7+k]};
        return w == tag;
    endfunction

    // Reference: search the concatenated block stream for the tags, then count runs.
    task automatic expect_run();
        int   lim;
        int   e;
        int   f;
        int   last;
        int   run;
        int   wc;
        int   nreq;
        res_t r;
        lim = MAXB * BLK; e = -1; f = -1; run = 0; wc = 0;
        for (int i = 7; i < lim; i++) if (tag_at(i, S_TAG)) begin e = i; break; end
        if (e >= 0) begin
            model_tag = START_ADDR + 32'(e / BLK);
            for (int i = e + 8; i < lim; i++) if (tag_at(i, E_TAG)) begin f = i; break; end
            last = (f >= 0) ? f : lim - 1;
            for (int i = e + 1; i <= last - 8; i++) begin
                if (word_ch(mem[i])) run++;
                else begin
                    if (run == WLEN) wc++;
                    run = 0;
                end
            end
            if (f >= 0 && run == WLEN) wc++;
        end
        nreq = (f >= 0) ? f / BLK + 1 : MAXB;
        for (int k = 0; k < nreq; k++) addr_q.push_back(START_ADDR + 32'(k));
        r.done = (f >= 0);
        r.fail = (f < 0);
        r.wc   = (wc > (2**CW) - 1) ? CW'((2**CW) - 1) : CW'(wc);
        r.tag  = model_tag;
        res_q.push_back(r);
    endtask

    task automatic fill_space();
        for (int i = 0; i < MEMB * BLK; i++) mem[i] = 8'h20;
    endtask

    task automatic fill_random();
        string alpha;
        string delim;
        int    p;
        int    n;
        alpha = "abcxyzQRS019";
        delim = " .,-1";
        p = 0;
        while (p < MEMB * BLK) begin
            n = $urandom_range(1, 5);
            for (int k = 0; k < n && p < MEMB * BLK; k++) begin
                mem[p] = alpha[$urandom_range(0, alpha.len() - 1)];
                p++;
            end
            if (p < MEMB * BLK) begin
                mem[p] = delim[$urandom_range(0, delim.len() - 1)];
                p++;
            end
        end
    endtask

    task automatic put_str(input int off, input string s);
        for (int i = 0; i < s.len(); i++) mem[off+i] = s[i];
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rd_req"}, rd_req, 0);
        check({tag, "_block_addr"}, block_addr, START_ADDR);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_fail"}, fail, 0);
        check({tag, "_word_count"}, word_count, 0);
        check({tag, "_tag_blk"}, tag_blk, 0);
    endtask

    task automatic wait_feeder();
        for (int c = 0; c < 2000 && pending; c++) @(negedge clk);
    endtask

    task automatic run_and_wait(input string name, input bit poke);
        bit ok;
        expect_run();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 8000; c++) begin
            if (done || fail) begin ok = 1'b1; break; end
            @(negedge clk);
            start = poke && (c == 200);
        end
        start = 1'b0;
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s_timeout: actual=busy required=done_or_fail", name);
        end
        wait_feeder();
        repeat (3) @(negedge clk);
        check({name, "_missing_rd_req"}, addr_q.size(), 0);
        check({name, "_missing_result"}, res_q.size(), 0);
        addr_q.delete();
        res_q.delete();
    endtask

    // SD controller model: answers each rd_req with 512 bytes, with random gaps.
    initial begin
        int cur_blk;
        int idx;
        int delay;
        sd_valid = 1'b0; sd_dout = 8'h00; pending = 1'b0;
        cur_blk = 0; idx = 0; delay = 0;
        forever begin
            @(negedge clk);
            sd_valid = 1'b0;
            if (rd_req) begin
                pending = 1'b1;
                cur_blk = int'(block_addr - START_ADDR);
                idx = 0;
                delay = $urandom_range(1, 3);
            end else if (pending) begin
                if (delay > 0) delay--;
                else if ($urandom_range(0, 3) != 0) begin
                    sd_valid = 1'b1;
                    sd_dout = (cur_blk >= 0 && cur_blk < MEMB) ? mem[cur_blk*BLK+idx] : 8'h20;
                    idx++;
                    if (idx == BLK) pending = 1'b0;
                end
            end
        end
    end

    // Monitor: every rd_req and every end of run is matched against the scoreboard.
    initial begin
        bit          prev_busy;
        logic [31:0] ea;
        res_t        r;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rd_req) begin
                if (addr_q.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL rd_req_unexpected: actual=%0h required=none", block_addr);
                end else begin
                    ea = addr_q.pop_front();
                    check("rd_req_addr", block_addr, ea);
                end
            end
            if (prev_busy && !busy && !rst) begin
                if (res_q.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL result_unexpected: actual=done%0d_fail%0d required=none", done, fail);
                end else begin
                    r = res_q.pop_front();
                    check("done", done, r.done);
                    check("fail", fail, r.fail);
                    check("word_count", word_count, r.wc);
                    check("tag_blk", tag_blk, r.tag);
                end
            end
            prev_busy = busy;
        end
    end

    initial begin
        int s_end;
        int e_off;
        rst = 1'b1; start = 1'b0; model_tag = '0;
        fill_space();
        repeat (3) @(negedge clk);
        check_reset_values("por");
        rst = 1'b0;

        fill_space();
        put_str(0, "DLAB_TAGthe cat ran DLAB_END");
        run_and_wait("single_block", 1'b0);

        fill_space();
        put_str(0, "DLAB_TAGabc1 ab abcd xyzDLAB_END");
        run_and_wait("alnum_mix", 1'b0);

        fill_space();
        put_str(3*BLK + 508, "DLAB_TAG");
        put_str(4*BLK + 8, "one two sixDLAB_END");
        run_and_wait("split_tag", 1'b0);

        fill_space();
        put_str(BLK + 504, "DLAB_TAG");
        put_str(2*BLK, "cat dogsDLAB_END");
        run_and_wait("tag_at_blk_end", 1'b0);

        fill_space();
        put_str(0, "DLAB_TAG");
        put_str(8, "foo bar");
        put_str(BLK - 8, "DLAB_END");
        run_and_wait("end_at_blk_end", 1'b0);

        fill_random();
        run_and_wait("no_tag", 1'b0);

        fill_random();
        put_str(2*BLK + 100, "DLAB_TAG");
        run_and_wait("no_end_start_poke", 1'b1);

        fill_space();
        put_str(0, "DLAB_TAGaaa bbb ccc ddd eee fff ggg hhh iii DLAB_END");
        run_and_wait("saturate", 1'b0);

        fill_random();
        put_str(BLK + 50, "DLAB_TAG");
        put_str(2*BLK + 300, "DLAB_END");
        expect_run();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (300) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("mid_rst");
        addr_q.delete();
        res_q.delete();
        model_tag = '0;
        @(negedge clk);
        rst = 1'b0;
        wait_feeder();
        repeat (4) @(negedge clk);
        run_and_wait("rescan", 1'b0);

        for (int t = 0; t < 6; t++) begin
            fill_random();
            s_end = $urandom_range(7, 4*BLK);
            put_str(s_end - 7, "DLAB_TAG");
            if ($urandom_range(0, 3) != 0) begin
                e_off = s_end + 1 + $urandom_range(0, 700);
                put_str(e_off, "DLAB_END");
            end
            run_and_wait("random", 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
